// File: rtl/ama_riscv_ctrl_pkg.sv
// ============================================================================
// Module  : ama_riscv_ctrl_pkg
// Brief   : Shared opcodes, PC-select / branch-select codes and flow-control
//           state encoding for the RISC-V pipeline control logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ama_riscv_ctrl_pkg;

  localparam logic [6:0] OPC7_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC7_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC7_JAL    = 7'b110_1111;

  localparam logic [1:0] PC_SEL_INC4       = 2'd0;
  localparam logic [1:0] PC_SEL_ALU        = 2'd1;
  localparam logic [1:0] PC_SEL_START_ADDR = 2'd2;

  // Branch select is {funct3[2], funct3[0]}
  localparam logic [1:0] BR_SEL_BEQ = 2'b00;
  localparam logic [1:0] BR_SEL_BNE = 2'b01;
  localparam logic [1:0] BR_SEL_BLT = 2'b10;
  localparam logic [1:0] BR_SEL_BGE = 2'b11;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } flow_state_e;

  function automatic logic is_ctrl_flow(input logic [6:0] opc);
    return (opc == OPC7_BRANCH) || (opc == OPC7_JAL) || (opc == OPC7_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ama_riscv_br_res.sv
// ============================================================================
// Module  : ama_riscv_br_res
// Brief   : Combinational branch resolution: latched funct3 and EX compare
//           flags to a taken decision; jumps are always taken.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ama_riscv_br_res
  import ama_riscv_ctrl_pkg::*;
(
  input  logic       i_is_jump,
  input  logic [2:0] i_funct3,
  input  logic       i_a_eq_b,
  input  logic       i_a_lt_b,
  output logic       o_taken
);

  logic [1:0] w_br_sel;
  logic       w_cond;
  logic       w_unused_f3;

  assign w_br_sel    = {i_funct3[2], i_funct3[0]};
  // Signed/unsigned variants differ only in how the datapath computes lt
  assign w_unused_f3 = i_funct3[1];

  always_comb begin
    w_cond = 1'b0;
    case (w_br_sel)
      BR_SEL_BEQ: w_cond = i_a_eq_b;
      BR_SEL_BNE: w_cond = ~i_a_eq_b;
      BR_SEL_BLT: w_cond = i_a_lt_b;
      BR_SEL_BGE: w_cond = i_a_eq_b | ~i_a_lt_b;
      default:    w_cond = 1'b0;
    endcase
  end

  assign o_taken = i_is_jump | w_cond;

endmodule

`default_nettype wire

// File: rtl/ama_riscv_flow_ctrl.sv
// ============================================================================
// Module  : ama_riscv_flow_ctrl
// Brief   : Pipeline flow control: post-reset clear sequence, control-flow
//           stalls and branch/jump PC redirection for an N-stage pipeline.
//           Optional perf counters enabled by AMA_RISCV_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ama_riscv_flow_ctrl
  import ama_riscv_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int BR_LAT     = 1,
  parameter int CNT_W      = 32
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           i_inst_id,
  input  logic                  i_bc_a_eq_b,
  input  logic                  i_bc_a_lt_b,
  output logic                  o_stall_if,
  output logic [NUM_STAGES-1:0] o_clear,
  output logic [1:0]            o_pc_sel,
  output logic                  o_pc_we,
`ifdef AMA_RISCV_PERF_CNT_EN
  output logic                  o_flow_change,
  output logic [CNT_W-1:0]      o_perf_stall_cnt,
  output logic [CNT_W-1:0]      o_perf_flush_cnt
`else
  output logic                  o_flow_change
`endif
);

  localparam int CNT_BITS = (BR_LAT < 2) ? 1 : $clog2(BR_LAT + 1);
  localparam logic [CNT_BITS-1:0] C_BR_LAT = CNT_BITS'(BR_LAT);
  localparam logic [CNT_BITS-1:0] C_ONE    = CNT_BITS'(1);

  if ((BR_LAT < 1) || (NUM_STAGES < 2) || (CNT_W < 1)) begin : g_param_err
    $error("ama_riscv_flow_ctrl: illegal parameter value");
  end

  flow_state_e           r_state;
  flow_state_e           w_next_state;
  logic [NUM_STAGES-1:0] r_rst_seq;
  logic [NUM_STAGES-1:0] w_flow_clr;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_is_jump;
  logic [2:0]            r_funct3;
  logic                  w_is_ctrl;
  logic                  w_latch;
  logic                  w_taken;
  logic                  w_unused;

  assign w_unused  = ^{i_inst_id[31:15], i_inst_id[11:7]};
  // rst_seq[1] is the only ID clear source while in ST_RUN
  assign w_is_ctrl = is_ctrl_flow(i_inst_id[6:0]) & ~r_rst_seq[1];

  ama_riscv_br_res u_br_res (
    .i_is_jump (r_is_jump),
    .i_funct3  (r_funct3),
    .i_a_eq_b  (i_bc_a_eq_b),
    .i_a_lt_b  (i_bc_a_lt_b),
    .o_taken   (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RST;
      r_rst_seq <= '1;
      r_cnt     <= '0;
      r_is_jump <= 1'b0;
      r_funct3  <= 3'b000;
    end else begin
      r_state   <= w_next_state;
      r_rst_seq <= r_rst_seq << 1;
      if (w_latch) begin
        r_cnt     <= C_BR_LAT;
        r_is_jump <= (i_inst_id[6:0] != OPC7_BRANCH);
        r_funct3  <= i_inst_id[14:12];
      end else if (r_state == ST_STALL) begin
        r_cnt <= r_cnt - C_ONE;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_latch       = 1'b0;
    w_flow_clr    = '0;
    o_stall_if    = 1'b0;
    o_pc_we       = 1'b1;
    o_pc_sel      = r_rst_seq[0] ? PC_SEL_START_ADDR : PC_SEL_INC4;
    o_flow_change = 1'b0;
    case (r_state)
      ST_RST: begin
        if (!r_rst_seq[0]) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_is_ctrl) begin
          o_stall_if   = 1'b1;
          o_pc_we      = 1'b0;
          w_latch      = 1'b1;
          w_next_state = ST_STALL;
        end
      end
      ST_STALL: begin
        w_flow_clr[1] = 1'b1;
        if (r_cnt == C_ONE) begin
          o_pc_sel      = w_taken ? PC_SEL_ALU : PC_SEL_INC4;
          o_flow_change = w_taken;
          w_next_state  = ST_RUN;
        end else begin
          o_stall_if = 1'b1;
          o_pc_we    = 1'b0;
        end
      end
      default: w_next_state = ST_RST;
    endcase
    o_clear = r_rst_seq | w_flow_clr;
  end

`ifdef AMA_RISCV_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall_cnt;
  logic [CNT_W-1:0] r_perf_flush_cnt;

  // Both counters saturate rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (o_stall_if && (r_perf_stall_cnt != '1))
        r_perf_stall_cnt <= r_perf_stall_cnt + CNT_W'(1);
      if (o_flow_change && (r_perf_flush_cnt != '1))
        r_perf_flush_cnt <= r_perf_flush_cnt + CNT_W'(1);
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

`default_nettype wire
